// File: rtl/regfile_mp.sv
// Multi-port register file with optional same-cycle write-to-read bypass and a
// per-register busy scoreboard used by the Decode-stage hazard logic.

module regfile_mp_rdport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       rst,
  input  logic [AW-1:0]              raddr,
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy,
  input  logic [NWR-1:0]             we,
  input  logic [NWR*AW-1:0]          waddr,
  input  logic [NWR*XLEN-1:0]        wdata,
  output logic [XLEN-1:0]            rdata,
  output logic                       rbusy
);
  logic            hit;
  logic [XLEN-1:0] byp;

  always_comb begin
    hit = 1'b0;
    byp = '0;
    // later write ports override earlier ones, matching the storage priority
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && waddr[k*AW +: AW] == raddr) begin
        hit = 1'b1;
        byp = wdata[k*XLEN +: XLEN];
      end
    end
    rdata = regs[raddr];
    rbusy = busy[raddr];
    if (BYPASS != 0 && hit && rst) begin
      rdata = byp;
      rbusy = 1'b0;
    end
    if (ZERO_REG != 0 && raddr == '0) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && waddr[k*AW +: AW] == AW'(i)) begin
          regs_d[i] = wdata[k*XLEN +: XLEN];
          busy_d[i] = 1'b0;
        end
      end
      // a new producer issued in the writeback cycle stays outstanding
      if (issue_en && issue_rd == AW'(i)) busy_d[i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NWR(NWR),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rst   (rst),
      .raddr (raddr[j*AW +: AW]),
      .regs  (regs_q),
      .busy  (busy_q),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[j*XLEN +: XLEN]),
      .rbusy (rbusy[j])
    );
  end

  assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dut_a (bypass, zero reg), dut_b (no bypass, no zero reg)
// share stimulus; dut_c is the 2-write/4-read bypass configuration.

module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr1;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [1:0]  we2;
  logic [9:0]  waddr2;
  logic [63:0] wdata2;
  logic [19:0] raddr2;

  logic [63:0]  rdata_a, rdata_b;
  logic [1:0]   rbusy_a, rbusy_b;
  logic [31:0]  busy_a, busy_b, busy_c;
  logic [127:0] rdata_c;
  logic [3:0]   rbusy_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst_n), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .raddr(raddr1), .rdata(rdata_a), .rbusy(rbusy_a),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_a));

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst_n), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .raddr(raddr1), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_b));

  regfile_mp #(.NRD(4), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .raddr(raddr2), .rdata(rdata_c), .rbusy(rbusy_c),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_c));

  task automatic idle();
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_en = 1'b0; issue_rd = '0;
    we2 = '0; waddr2 = '0; wdata2 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); raddr1 = {5'd1, 5'd0}; raddr2 = '0;
    @(posedge clk); @(negedge clk);
    nvec++; if (busy_a !== 32'h0) begin nerr++; $display("FAIL reset_busy_a got %h exp %h", busy_a, 32'h0); end
    nvec++; if (busy_c !== 32'h0) begin nerr++; $display("FAIL reset_busy_c got %h exp %h", busy_c, 32'h0); end
    nvec++; if (rdata_b !== 64'h0) begin nerr++; $display("FAIL reset_rdata_b got %h exp %h", rdata_b, 64'h0); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h12345678; raddr1 = {5'd0, 5'd3};
    @(negedge clk);
    nvec++; if (rdata_a[31:0] !== 32'h12345678) begin nerr++; $display("FAIL bypass_same_cycle got %h exp %h", rdata_a[31:0], 32'h12345678); end
    nvec++; if (rdata_b[31:0] !== 32'h0) begin nerr++; $display("FAIL nobypass_old got %h exp %h", rdata_b[31:0], 32'h0); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (rdata_b[31:0] !== 32'h12345678) begin nerr++; $display("FAIL nobypass_next got %h exp %h", rdata_b[31:0], 32'h12345678); end
    nvec++; if (rdata_a[31:0] !== 32'h12345678) begin nerr++; $display("FAIL bypass_stored got %h exp %h", rdata_a[31:0], 32'h12345678); end
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_rd = 5'd0; raddr1 = {5'd3, 5'd0};
    @(negedge clk);
    nvec++; if (rdata_a[31:0] !== 32'h0) begin nerr++; $display("FAIL zero_bypass got %h exp %h", rdata_a[31:0], 32'h0); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (rdata_a[31:0] !== 32'h0) begin nerr++; $display("FAIL zero_read got %h exp %h", rdata_a[31:0], 32'h0); end
    nvec++; if (busy_a[0] !== 1'b0) begin nerr++; $display("FAIL zero_busy got %b exp %b", busy_a[0], 1'b0); end
    nvec++; if (rdata_b[31:0] !== 32'hFFFFFFFF) begin nerr++; $display("FAIL nozero_read got %h exp %h", rdata_b[31:0], 32'hFFFFFFFF); end
    nvec++; if (busy_b[0] !== 1'b1) begin nerr++; $display("FAIL nozero_busy got %b exp %b", busy_b[0], 1'b1); end
  endtask

  task automatic test_scoreboard();
    @(posedge clk); #1;
    issue_en = 1'b1; issue_rd = 5'd9; raddr1 = {5'd3, 5'd9};
    @(negedge clk);
    nvec++; if (busy_a[9] !== 1'b0) begin nerr++; $display("FAIL sb_not_yet got %b exp %b", busy_a[9], 1'b0); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (busy_a[9] !== 1'b1) begin nerr++; $display("FAIL sb_set got %b exp %b", busy_a[9], 1'b1); end
    nvec++; if (rbusy_a[0] !== 1'b1) begin nerr++; $display("FAIL sb_rbusy got %b exp %b", rbusy_a[0], 1'b1); end
    @(posedge clk); #1;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h55;
    @(negedge clk);
    nvec++; if (rbusy_a[0] !== 1'b0) begin nerr++; $display("FAIL sb_rbusy_byp got %b exp %b", rbusy_a[0], 1'b0); end
    nvec++; if (rdata_a[31:0] !== 32'h55) begin nerr++; $display("FAIL sb_rdata_byp got %h exp %h", rdata_a[31:0], 32'h55); end
    nvec++; if (rbusy_b[0] !== 1'b1) begin nerr++; $display("FAIL sb_rbusy_nobyp got %b exp %b", rbusy_b[0], 1'b1); end
    nvec++; if (busy_a[9] !== 1'b1) begin nerr++; $display("FAIL sb_hold got %b exp %b", busy_a[9], 1'b1); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (busy_a[9] !== 1'b0) begin nerr++; $display("FAIL sb_clear_a got %b exp %b", busy_a[9], 1'b0); end
    nvec++; if (busy_b[9] !== 1'b0) begin nerr++; $display("FAIL sb_clear_b got %b exp %b", busy_b[9], 1'b0); end
  endtask

  task automatic test_issue_write();
    @(posedge clk); #1;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hCAFE0012;
    issue_en = 1'b1; issue_rd = 5'd12; raddr1 = {5'd3, 5'd12};
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (busy_a[12] !== 1'b1) begin nerr++; $display("FAIL iw_busy got %b exp %b", busy_a[12], 1'b1); end
    nvec++; if (rdata_a[31:0] !== 32'hCAFE0012) begin nerr++; $display("FAIL iw_data got %h exp %h", rdata_a[31:0], 32'hCAFE0012); end
    @(posedge clk); #1 issue_en = 1'b1; issue_rd = 5'd12;
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (busy_a[12] !== 1'b1) begin nerr++; $display("FAIL reissue_busy got %b exp %b", busy_a[12], 1'b1); end
    @(posedge clk); #1 we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0BADF00D;
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (busy_a[12] !== 1'b0) begin nerr++; $display("FAIL reissue_clear got %b exp %b", busy_a[12], 1'b0); end
    nvec++; if (rdata_a[63:32] !== 32'h12345678) begin nerr++; $display("FAIL port1_read got %h exp %h", rdata_a[63:32], 32'h12345678); end
  endtask

  task automatic test_dual_write();
    @(posedge clk); #1;
    we2 = 2'b11; waddr2 = {5'd4, 5'd4}; wdata2 = {32'h0000BBBB, 32'h0000AAAA};
    raddr2 = {5'd4, 5'd4, 5'd4, 5'd4};
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      nvec++; if (rdata_c[j*32 +: 32] !== 32'h0000BBBB) begin nerr++; $display("FAIL dual_byp port%0d got %h exp %h", j, rdata_c[j*32 +: 32], 32'h0000BBBB); end
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      nvec++; if (rdata_c[j*32 +: 32] !== 32'h0000BBBB) begin nerr++; $display("FAIL dual_store port%0d got %h exp %h", j, rdata_c[j*32 +: 32], 32'h0000BBBB); end
    end
    @(posedge clk); #1;
    we2 = 2'b11; waddr2 = {5'd5, 5'd4}; wdata2 = {32'h00002222, 32'h00001111};
    raddr2 = {5'd4, 5'd0, 5'd5, 5'd4};
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (rdata_c !== {32'h1111, 32'h0, 32'h2222, 32'h1111}) begin nerr++; $display("FAIL split_write got %h exp %h", rdata_c, {32'h1111, 32'h0, 32'h2222, 32'h1111}); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF;
    issue_en = 1'b1; issue_rd = 5'd7; raddr1 = {5'd7, 5'd5};
    @(posedge clk); #1 idle();
    @(negedge clk);
    nvec++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin nerr++; $display("FAIL mid_pre_data got %h exp %h", rdata_a[31:0], 32'hDEADBEEF); end
    nvec++; if (busy_a[7] !== 1'b1) begin nerr++; $display("FAIL mid_pre_busy got %b exp %b", busy_a[7], 1'b1); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (rdata_a[31:0] !== 32'h0) begin nerr++; $display("FAIL mid_rst_data got %h exp %h", rdata_a[31:0], 32'h0); end
    nvec++; if (busy_a !== 32'h0) begin nerr++; $display("FAIL mid_rst_busy got %h exp %h", busy_a, 32'h0); end
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h00001234;
    #1;
    nvec++; if (rdata_a[31:0] !== 32'h0) begin nerr++; $display("FAIL rst_no_bypass got %h exp %h", rdata_a[31:0], 32'h0); end
    @(posedge clk); #1 idle(); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    nvec++; if (rdata_a[31:0] !== 32'h0) begin nerr++; $display("FAIL post_rst_data got %h exp %h", rdata_a[31:0], 32'h0); end
    nvec++; if (busy_a !== 32'h0) begin nerr++; $display("FAIL post_rst_busy got %h exp %h", busy_a, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_issue_write();
    test_dual_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
